// File: rtl/nv_ram_rws_64x512_fifo_ctrl_pkg.sv
// Shared constants, types and helpers for the 64x512 RAM FIFO controller.
// Occupancy can reach DEPTH + OBUF_DEPTH, so counts need one extra code point.
package nv_ram_fifo_pkg;

   localparam int DEPTH      = 64;
   localparam int AW         = 6;
   localparam int DW         = 512;
   localparam int OBUF_DEPTH = 2;
   localparam int CW         = $clog2(DEPTH + OBUF_DEPTH + 1);

   typedef logic [AW-1:0] addr_t;
   typedef logic [DW-1:0] data_t;
   typedef logic [CW-1:0] cnt_t;

   function automatic addr_t ptr_inc(input addr_t p);
      return p + addr_t'(1);
   endfunction

endpackage

// File: rtl/nv_ram_rws_64x512_fifo_ctrl_if.sv
// Producer, consumer and RAM-port signals of the FIFO controller.
// The slave modport is the controller's view; master is the surrounding logic.
interface nv_ram_rws_64x512_fifo_ctrl_if;
   import nv_ram_fifo_pkg::*;

   logic        wr_pvld;
   logic        wr_prdy;
   data_t       wr_pd;
   logic        rd_pvld;
   logic        rd_prdy;
   data_t       rd_pd;
   addr_t       ram_wa;
   logic        ram_we;
   data_t       ram_di;
   addr_t       ram_ra;
   logic        ram_re;
   data_t       ram_dout;
   cnt_t        fifo_cnt;
   logic [31:0] pwrbus_ram_pd;

   modport slave (
      input  wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
      output wr_prdy, rd_pvld, rd_pd, ram_wa, ram_we, ram_di, ram_ra, ram_re, fifo_cnt
   );

   modport master (
      output wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
      input  wr_prdy, rd_pvld, rd_pd, ram_wa, ram_we, ram_di, ram_ra, ram_re, fifo_cnt
   );

endinterface

// File: rtl/nv_ram_rws_64x512_fifo_ctrl_obuf.sv
// Two-entry in-order output buffer that absorbs the RAM read latency.
// The head register drives the consumer directly; the tail only fills when the head is held.
module nv_ram_fifo_obuf
   import nv_ram_fifo_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_cap,
   input  data_t      i_cap_data,
   input  logic       i_rdy,
   output logic       o_vld,
   output data_t      o_data,
   output logic [1:0] o_cnt,
   output logic       o_pop
);

   logic [1:0] r_cnt;
   logic       r_vld;
   data_t      r_head;
   data_t      r_tail;

   logic       w_pop;
   logic [1:0] w_cnt_nxt;
   data_t      w_head_nxt;
   data_t      w_tail_nxt;

   assign w_pop  = r_vld & i_rdy;
   assign o_vld  = r_vld;
   assign o_data = r_head;
   assign o_cnt  = r_cnt;
   assign o_pop  = w_pop;

   // Next buffer contents from this cycle's capture and pop
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      case ({i_cap, w_pop})
         2'b10: begin
            if (r_cnt == 2'd0) begin
               w_head_nxt = i_cap_data;
               w_cnt_nxt  = 2'd1;
            end else begin
               w_tail_nxt = i_cap_data;
               w_cnt_nxt  = 2'd2;
            end
         end
         2'b01: begin
            if (r_cnt == 2'd2) begin
               w_head_nxt = r_tail;
            end else begin
               w_head_nxt = r_head;
            end
            w_cnt_nxt = r_cnt - 2'd1;
         end
         2'b11: begin
            if (r_cnt == 2'd1) begin
               w_head_nxt = i_cap_data;
            end else begin
               w_head_nxt = r_tail;
               w_tail_nxt = i_cap_data;
            end
         end
         default: begin
            w_cnt_nxt = r_cnt;
         end
      endcase
   end

   // Buffer state registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt  <= 2'd0;
         r_vld  <= 1'b0;
         r_head <= {DW{1'b0}};
         r_tail <= {DW{1'b0}};
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_vld  <= (w_cnt_nxt != 2'd0);
         r_head <= w_head_nxt;
         r_tail <= w_tail_nxt;
      end
   end

endmodule

// File: rtl/nv_ram_rws_64x512_fifo_ctrl.sv
// Valid/ready FIFO wrapper around the 64x512 registered-read-address RAM.
// Holds the pointers, the RAM occupancy, the read-issue decision and the total count.
module nv_ram_rws_64x512_fifo_ctrl
   import nv_ram_fifo_pkg::*;
(
   input  logic                          nvdla_core_clk,
   input  logic                          nvdla_core_rstn,
   nv_ram_rws_64x512_fifo_ctrl_if.slave  bus
);

   addr_t      r_wr_ptr;
   addr_t      r_rd_ptr;
   cnt_t       r_ram_cnt;
   logic       r_inflight;
   logic       r_wr_prdy;
   cnt_t       r_fifo_cnt;

   logic       w_accept;
   logic       w_issue;
   logic       w_pop;
   logic       w_rd_pvld;
   data_t      w_rd_pd;
   logic [1:0] w_buf_cnt;
   logic [2:0] w_pending;
   cnt_t       w_ram_cnt_nxt;
   cnt_t       w_fifo_cnt_nxt;

   assign w_accept     = bus.wr_pvld & r_wr_prdy;

   assign bus.wr_prdy  = r_wr_prdy;
   assign bus.ram_we   = w_accept;
   assign bus.ram_wa   = r_wr_ptr;
   assign bus.ram_di   = bus.wr_pd;
   assign bus.ram_re   = w_issue;
   assign bus.ram_ra   = r_rd_ptr;
   assign bus.rd_pvld  = w_rd_pvld;
   assign bus.rd_pd    = w_rd_pd;
   assign bus.fifo_cnt = r_fifo_cnt;

   nv_ram_fifo_obuf u_obuf (
      .i_clk      (nvdla_core_clk),
      .i_rstn     (nvdla_core_rstn),
      .i_cap      (r_inflight),
      .i_cap_data (bus.ram_dout),
      .i_rdy      (bus.rd_prdy),
      .o_vld      (w_rd_pvld),
      .o_data     (w_rd_pd),
      .o_cnt      (w_buf_cnt),
      .o_pop      (w_pop)
   );

   // Issue a read only if the buffer will still have room when its data lands
   always_comb begin
      w_pending = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
      if ((r_ram_cnt != {CW{1'b0}}) && (w_pending < 3'd2)) begin
         w_issue = 1'b1;
      end else begin
         w_issue = 1'b0;
      end
      w_ram_cnt_nxt  = r_ram_cnt + cnt_t'(w_accept) - cnt_t'(w_issue);
      w_fifo_cnt_nxt = w_ram_cnt_nxt + cnt_t'(w_issue) + cnt_t'(w_pending);
   end

   // Pointer, occupancy and flow-control registers
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_wr_ptr   <= {AW{1'b0}};
         r_rd_ptr   <= {AW{1'b0}};
         r_ram_cnt  <= {CW{1'b0}};
         r_inflight <= 1'b0;
         r_wr_prdy  <= 1'b0;
         r_fifo_cnt <= {CW{1'b0}};
      end else begin
         if (w_accept) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_issue) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_ram_cnt  <= w_ram_cnt_nxt;
         r_inflight <= w_issue;
         r_wr_prdy  <= (w_ram_cnt_nxt < cnt_t'(DEPTH));
         r_fifo_cnt <= w_fifo_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_nv_ram_rws_64x512_fifo_ctrl.sv
// Bench for the RAM FIFO controller: behavioural RAM plus a queue-based FIFO model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_nv_ram_rws_64x512_fifo_ctrl;
   import nv_ram_fifo_pkg::*;

   logic  clk  = 1'b0;
   logic  rstn = 1'b0;
   int    errors = 0;
   int    checks = 0;
   data_t model_q[$];

   logic  s_acc, s_pop, s_re, s_we, s_vld, s_prdy;
   addr_t s_ra, s_wa;
   data_t s_pd;
   cnt_t  s_cnt;

   nv_ram_rws_64x512_fifo_ctrl_if u_if ();

   nv_ram_rws_64x512_fifo_ctrl u_dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .bus             (u_if.slave)
   );

   always #5 clk = ~clk;

   // Registered-read-address RAM: the address is captured on ram_re, data read from it
   data_t mem [DEPTH];
   addr_t ram_ra_q;
   always @(posedge clk) begin
      if (u_if.ram_we) mem[u_if.ram_wa] <= u_if.ram_di;
      if (u_if.ram_re) ram_ra_q <= u_if.ram_ra;
   end
   assign u_if.ram_dout = mem[ram_ra_q];

   function automatic data_t mk(input int i);
      data_t d;
      d = {16{32'(i)}};
      return d;
   endfunction

   task automatic drive_cycle(input logic wv, input data_t wd, input logic rp);
      @(negedge clk);
      u_if.wr_pvld = wv;
      u_if.wr_pd   = wd;
      u_if.rd_prdy = rp;
      #1;
      s_prdy = u_if.wr_prdy;
      s_acc  = wv & s_prdy;
      s_vld  = u_if.rd_pvld;
      s_pop  = s_vld & rp;
      s_pd   = u_if.rd_pd;
      s_re   = u_if.ram_re;
      s_ra   = u_if.ram_ra;
      s_we   = u_if.ram_we;
      s_wa   = u_if.ram_wa;
      s_cnt  = u_if.fifo_cnt;
      @(posedge clk);
   endtask

   task automatic test_reset();
      u_if.wr_pvld = 1'b0; u_if.wr_pd = '0; u_if.rd_prdy = 1'b0; u_if.pwrbus_ram_pd = 32'h0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (u_if.wr_prdy !== 1'b0) begin errors++; $display("FAIL reset_wr_prdy: got %0b expected 0", u_if.wr_prdy); end
      checks++; if (u_if.rd_pvld !== 1'b0) begin errors++; $display("FAIL reset_rd_pvld: got %0b expected 0", u_if.rd_pvld); end
      checks++; if (u_if.fifo_cnt !== 7'd0) begin errors++; $display("FAIL reset_fifo_cnt: got %0d expected 0", u_if.fifo_cnt); end
      checks++; if (u_if.rd_pd !== {DW{1'b0}}) begin errors++; $display("FAIL reset_rd_pd: got %0h expected 0", u_if.rd_pd); end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++; if (u_if.wr_prdy !== 1'b0) begin errors++; $display("FAIL release_wr_prdy_early: got %0b expected 0", u_if.wr_prdy); end
      for (int c = 0; c < 5; c++) begin
         drive_cycle(1'b0, '0, 1'b1);
         checks++; if (s_prdy !== 1'b1) begin errors++; $display("FAIL idle_wr_prdy c%0d: got %0b expected 1", c, s_prdy); end
         checks++; if (s_re !== 1'b0 || s_vld !== 1'b0 || s_cnt !== 7'd0) begin
            errors++; $display("FAIL idle_quiet c%0d: re=%0b vld=%0b cnt=%0d expected 0 0 0", c, s_re, s_vld, s_cnt);
         end
      end
   endtask

   task automatic test_single();
      data_t v, exp;
      v = {64{8'hA5}};
      drive_cycle(1'b1, v, 1'b1);
      if (s_acc) model_q.push_back(v);
      checks++; if (s_acc !== 1'b1 || s_we !== 1'b1 || s_wa !== 6'd0) begin
         errors++; $display("FAIL single_write: acc=%0b we=%0b wa=%0d expected 1 1 0", s_acc, s_we, s_wa);
      end
      drive_cycle(1'b0, '0, 1'b1);
      checks++; if (s_re !== 1'b1 || s_ra !== 6'd0) begin errors++; $display("FAIL single_issue: re=%0b ra=%0d expected 1 0", s_re, s_ra); end
      checks++; if (s_cnt !== 7'd1) begin errors++; $display("FAIL single_cnt1: got %0d expected 1", s_cnt); end
      drive_cycle(1'b0, '0, 1'b1);
      checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL single_early_vld: got %0b expected 0", s_vld); end
      drive_cycle(1'b0, '0, 1'b1);
      checks++; if (s_vld !== 1'b1) begin errors++; $display("FAIL single_vld_cycle3: got %0b expected 1", s_vld); end
      if (s_pop && model_q.size() > 0) begin
         exp = model_q.pop_front();
         checks++; if (s_pd !== exp) begin errors++; $display("FAIL single_data: got %0h expected %0h", s_pd, exp); end
      end
      drive_cycle(1'b0, '0, 1'b1);
      checks++; if (s_cnt !== 7'd0 || s_vld !== 1'b0) begin errors++; $display("FAIL single_drained: cnt=%0d vld=%0b expected 0 0", s_cnt, s_vld); end
   endtask

   task automatic test_fill();
      int next = 0;
      int popped = 0;
      data_t exp;
      for (int c = 0; c < 100; c++) begin
         drive_cycle(1'b1, mk(next), 1'b0);
         if (s_acc) begin model_q.push_back(mk(next)); next++; end
      end
      checks++; if (next !== 66) begin errors++; $display("FAIL fill_accepted: got %0d expected 66", next); end
      drive_cycle(1'b0, '0, 1'b0);
      checks++; if (s_cnt !== 7'd66) begin errors++; $display("FAIL fill_cnt: got %0d expected 66", s_cnt); end
      checks++; if (s_prdy !== 1'b0) begin errors++; $display("FAIL fill_wr_prdy: got %0b expected 0", s_prdy); end
      for (int c = 0; c < 300 && model_q.size() > 0; c++) begin
         drive_cycle(1'b0, '0, 1'b1);
         if (s_pop) begin
            exp = model_q.pop_front();
            popped++;
            checks++; if (s_pd !== exp) begin errors++; $display("FAIL fill_drain_data #%0d: got %0h expected %0h", popped, s_pd, exp); end
         end
      end
      checks++; if (popped !== 66) begin errors++; $display("FAIL fill_drain_count: got %0d expected 66", popped); end
      drive_cycle(1'b0, '0, 1'b1);
      checks++; if (s_vld !== 1'b0 || s_cnt !== 7'd0) begin errors++; $display("FAIL fill_empty: vld=%0b cnt=%0d expected 0 0", s_vld, s_cnt); end
   endtask

   task automatic test_back_to_back();
      int sent = 0, popped = 0, first = -1, last = -1, stalls = 0;
      logic wv;
      data_t exp;
      for (int c = 0; c < 260 && popped < 200; c++) begin
         wv = (sent < 200);
         drive_cycle(wv, mk(1000 + sent), 1'b1);
         if (wv && !s_acc) stalls++;
         if (s_acc) begin model_q.push_back(mk(1000 + sent)); sent++; end
         if (s_pop) begin
            if (first < 0) first = c;
            last = c;
            exp = model_q.pop_front();
            popped++;
            checks++; if (s_pd !== exp) begin errors++; $display("FAIL stream_data #%0d: got %0h expected %0h", popped, s_pd, exp); end
         end
      end
      checks++; if (popped !== 200) begin errors++; $display("FAIL stream_count: got %0d expected 200", popped); end
      checks++; if (first !== 3) begin errors++; $display("FAIL stream_first_pop: got %0d expected 3", first); end
      checks++; if (last - first !== 199) begin errors++; $display("FAIL stream_rate: got span %0d expected 199", last - first); end
      checks++; if (stalls !== 0) begin errors++; $display("FAIL stream_wr_stalls: got %0d expected 0", stalls); end
   endtask

   task automatic test_random();
      int sent = 0, popped = 0;
      logic wv, rp, prev_stall;
      data_t prev_pd, exp;
      prev_stall = 1'b0;
      prev_pd    = '0;
      for (int c = 0; c < 30000 && popped < 1000; c++) begin
         wv = (sent < 1000) && ($urandom_range(1, 0) == 1);
         rp = ($urandom_range(1, 0) == 1);
         drive_cycle(wv, mk(20000 + sent), rp);
         checks++; if (s_cnt !== cnt_t'(model_q.size())) begin
            errors++; $display("FAIL rand_fifo_cnt c%0d: got %0d expected %0d", c, s_cnt, model_q.size());
         end
         if (prev_stall) begin
            checks++; if (s_vld !== 1'b1 || s_pd !== prev_pd) begin
               errors++; $display("FAIL rand_stall_hold c%0d: vld=%0b pd=%0h expected 1 %0h", c, s_vld, s_pd, prev_pd);
            end
         end
         prev_stall = s_vld & ~rp;
         prev_pd    = s_pd;
         if (s_acc) begin model_q.push_back(mk(20000 + sent)); sent++; end
         if (s_pop) begin
            exp = model_q.pop_front();
            popped++;
            checks++; if (s_pd !== exp) begin errors++; $display("FAIL rand_data #%0d: got %0h expected %0h", popped, s_pd, exp); end
         end
      end
      checks++; if (popped !== 1000) begin errors++; $display("FAIL rand_count: got %0d expected 1000", popped); end
   endtask

   task automatic test_reset_mid();
      int sent = 0, popped = 0;
      data_t exp;
      for (int c = 0; c < 100 && sent < 30; c++) begin
         drive_cycle(1'b1, mk(5000 + sent), 1'b0);
         if (s_acc) begin model_q.push_back(mk(5000 + sent)); sent++; end
      end
      drive_cycle(1'b0, '0, 1'b0);
      checks++; if (s_cnt !== 7'd30) begin errors++; $display("FAIL mid_cnt_before: got %0d expected 30", s_cnt); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (u_if.wr_prdy !== 1'b0 || u_if.rd_pvld !== 1'b0 || u_if.fifo_cnt !== 7'd0 || u_if.ram_re !== 1'b0) begin
         errors++; $display("FAIL mid_async_reset: prdy=%0b vld=%0b cnt=%0d re=%0b expected 0 0 0 0",
                            u_if.wr_prdy, u_if.rd_pvld, u_if.fifo_cnt, u_if.ram_re);
      end
      checks++; if (u_if.rd_pd !== {DW{1'b0}}) begin errors++; $display("FAIL mid_async_rd_pd: got %0h expected 0", u_if.rd_pd); end
      model_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      sent = 0;
      for (int c = 0; c < 40; c++) begin
         drive_cycle(sent < 2, data_t'(sent + 1), 1'b1);
         if (s_acc) begin model_q.push_back(data_t'(sent + 1)); sent++; end
         if (s_pop) begin
            popped++;
            if (model_q.size() > 0) begin
               exp = model_q.pop_front();
               checks++; if (s_pd !== exp) begin errors++; $display("FAIL mid_after_data #%0d: got %0h expected %0h", popped, s_pd, exp); end
            end
         end
      end
      checks++; if (popped !== 2) begin errors++; $display("FAIL mid_after_count: got %0d expected 2", popped); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
